// File: rtl/arb_req_ctl.sv
// Requester-side controller for an asynchronous mutex-tree arbiter.
// Each channel turns client req/done into a four-phase arb_req/arb_gnt handshake and enforces an optional hold limit.
module arb_req_ctl #(
  parameter int MR      = 4,
  parameter int SYNC    = 2,
  parameter int MAXHOLD = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [MR-1:0] cli_req,
  input  logic [MR-1:0] cli_done,
  output logic [MR-1:0] cli_gnt,
  output logic [MR-1:0] cli_abort,
  output logic [MR-1:0] arb_req,
  input  logic [MR-1:0] arb_gnt,
  output logic          err
);

  localparam int CW = (MAXHOLD > 0) ? $clog2(MAXHOLD + 1) : 1;
  localparam logic [CW-1:0] HOLD_LAST = (MAXHOLD > 0) ? CW'(MAXHOLD - 1) : '0;

  typedef enum logic [1:0] {IDLE, REQ, OWN, REL} state_e;

  state_e        state_q   [MR];
  logic [CW-1:0] hold_q    [MR];
  logic [MR-1:0] sync_q    [SYNC];
  logic [MR-1:0] gs;
  logic [MR-1:0] arb_req_q;
  logic [MR-1:0] cli_gnt_q;
  logic [MR-1:0] cli_abort_q;
  logic          err_q;

  assign gs        = sync_q[SYNC-1];
  assign arb_req   = arb_req_q;
  assign cli_gnt   = cli_gnt_q;
  assign cli_abort = cli_abort_q;
  assign err       = err_q;

  // Synchronisers reset high and channels start in REL: a stale grant must drain before IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < SYNC; k++) sync_q[k] <= '1;
      for (int unsigned i = 0; i < MR; i++) begin
        state_q[i] <= REL;
        hold_q[i]  <= '0;
      end
      arb_req_q   <= '0;
      cli_gnt_q   <= '0;
      cli_abort_q <= '0;
      err_q       <= 1'b0;
    end else begin
      sync_q[0] <= arb_gnt;
      for (int unsigned k = 1; k < SYNC; k++) sync_q[k] <= sync_q[k-1];

      for (int unsigned i = 0; i < MR; i++) begin
        cli_abort_q[i] <= 1'b0;
        case (state_q[i])
          IDLE: begin
            if (gs[i]) err_q <= 1'b1;
            if (cli_req[i]) begin
              state_q[i]   <= REQ;
              arb_req_q[i] <= 1'b1;
            end
          end
          REQ: begin
            if (gs[i]) begin
              state_q[i]   <= OWN;
              cli_gnt_q[i] <= 1'b1;
              hold_q[i]    <= '0;
            end
          end
          OWN: begin
            if (cli_done[i]) begin
              state_q[i]   <= REL;
              arb_req_q[i] <= 1'b0;
              cli_gnt_q[i] <= 1'b0;
            end else if ((MAXHOLD > 0) && (hold_q[i] == HOLD_LAST)) begin
              state_q[i]     <= REL;
              arb_req_q[i]   <= 1'b0;
              cli_gnt_q[i]   <= 1'b0;
              cli_abort_q[i] <= 1'b1;
            end else if (MAXHOLD > 0) begin
              hold_q[i] <= hold_q[i] + 1'b1;
            end
          end
          REL: begin
            if (!gs[i]) state_q[i] <= IDLE;
          end
          default: state_q[i] <= REL;
        endcase
      end
    end
  end

endmodule
